// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling feeding a first-word-fall-through byte FIFO.
// Framing and overrun errors are held in sticky flags until err_clr.
//
// state | meaning
// ARM   | wait for CLKS_PER_BIT consecutive high samples before accepting a start edge
// IDLE  | line known idle, watching for a falling edge
// START | confirm the start bit at its midpoint
// DATA  | shift in 8 data bits, LSB first, at mid-bit
// STOP  | check the stop bit, then queue the byte or flag a framing error
module uart_rx_fifo #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       sys_clk,
   input  logic       reset_n,
   input  logic       rxd,
   input  logic       rd_en,
   input  logic       err_clr,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       fifo_full,
   output logic       rx_busy,
   output logic       frame_err,
   output logic       overrun
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [2:0] S_ARM   = 3'd0;
   localparam logic [2:0] S_IDLE  = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;

   logic          r_sync1, r_sync2, r_sync_q;
   logic [2:0]    r_state;
   logic [TW-1:0] r_timer;
   logic [2:0]    r_idx;
   logic [7:0]    r_shift;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_frame_err, r_overrun;

   logic w_t_half, w_t_end, w_stop_sample, w_byte_done, w_frame_bad;
   logic w_full, w_pop, w_push;

   // r_sync_q holds the previous synchronized sample for falling-edge detection
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_sync_q <= 1'b1;
      end else begin
         r_sync1  <= rxd;
         r_sync2  <= r_sync1;
         r_sync_q <= r_sync2;
      end
   end

   assign w_t_half      = (r_timer == TW'(CLKS_PER_BIT / 2 - 1));
   assign w_t_end       = (r_timer == TW'(CLKS_PER_BIT - 1));
   assign w_stop_sample = (r_state == S_STOP) && w_t_end;
   assign w_byte_done   = w_stop_sample && r_sync2;
   assign w_frame_bad   = w_stop_sample && !r_sync2;

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_ARM;
         r_timer <= '0;
         r_idx   <= '0;
         r_shift <= '0;
      end else begin
         case (r_state)
            S_ARM: begin
               if (!r_sync2) begin
                  r_timer <= '0;
               end else if (w_t_end) begin
                  r_timer <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            S_IDLE: begin
               if (r_sync_q && !r_sync2) begin
                  r_timer <= '0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_t_half) begin
                  r_timer <= '0;
                  r_idx   <= '0;
                  r_state <= r_sync2 ? S_IDLE : S_DATA;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            S_DATA: begin
               if (w_t_end) begin
                  r_timer        <= '0;
                  r_shift[r_idx] <= r_sync2;
                  r_idx          <= r_idx + 3'd1;
                  if (r_idx == 3'd7) r_state <= S_STOP;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            S_STOP: begin
               if (w_t_end) begin
                  r_timer <= '0;
                  r_state <= r_sync2 ? S_IDLE : S_ARM;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            default: begin
               r_timer <= '0;
               r_state <= S_ARM;
            end
         endcase
      end
   end

   // a pop frees the slot, so a byte arriving while full is still accepted
   assign w_full = (r_count == (AW + 1)'(FIFO_DEPTH));
   assign w_pop  = rd_en && (r_count != '0);
   assign w_push = w_byte_done && (!w_full || w_pop);

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + (AW + 1)'(1);
         else if (w_pop && !w_push) r_count <= r_count - (AW + 1)'(1);
      end
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= w_frame_bad || (r_frame_err && !err_clr);
         r_overrun   <= (w_byte_done && w_full && !w_pop) || (r_overrun && !err_clr);
      end
   end

   assign rd_data   = r_mem[r_rd_ptr];
   assign rd_valid  = (r_count != '0);
   assign fifo_full = w_full;
   assign rx_busy   = (r_state != S_ARM) && (r_state != S_IDLE);
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo at 10 clocks per bit and a 4-entry FIFO.
// Expected bytes go into a scoreboard queue as frames are driven and are compared on each pop.
module tb_uart_rx_fifo;

   localparam int CPB   = 10;
   localparam int DEPTH = 4;

   logic       sys_clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       rxd     = 1'b1;
   logic       rd_en   = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid, fifo_full, rx_busy, frame_err, overrun;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] sb_q [$];
   int         model_count = 0;
   logic       exp_overrun = 1'b0;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_valid;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs [6];

   uart_rx_fifo #(
      .CLK_HZ    (1_152_000),
      .BAUD      (115_200),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .sys_clk  (sys_clk),
      .reset_n  (reset_n),
      .rxd      (rxd),
      .rd_en    (rd_en),
      .err_clr  (err_clr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .fifo_full(fifo_full),
      .rx_busy  (rx_busy),
      .frame_err(frame_err),
      .overrun  (overrun)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic wait_clk(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b);
      rxd = 1'b0;
      wait_clk(CPB);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         wait_clk(CPB);
      end
      rxd = stop_b;
      wait_clk(CPB);
      rxd = 1'b1;
   endtask

   // model update happens as the frame is driven
   task automatic send_good(input logic [7:0] d);
      if (model_count < DEPTH) begin
         sb_q.push_back(d);
         model_count++;
      end else begin
         exp_overrun = 1'b1;
      end
      send_frame(d, 1'b1);
   endtask

   task automatic pop_check(input string name);
      n_checks++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty, rd_valid=%0b", name, rd_valid);
      end else if (rd_valid !== 1'b1 || rd_data !== sb_q[0]) begin
         n_fail++;
         $display("FAIL %s: actual valid=%0b data=%0h expected valid=1 data=%0h",
                  name, rd_valid, rd_data, sb_q[0]);
      end
      if (sb_q.size() != 0) begin
         void'(sb_q.pop_front());
         model_count--;
      end
      rd_en = 1'b1;
      wait_clk(1);
      rd_en = 1'b0;
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      wait_clk(1);
      err_clr = 1'b0;
      exp_overrun = 1'b0;
   endtask

   initial begin
      logic busy_seen, valid_seen;

      vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{8'h12, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{8'h80, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{8'hAA, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{8'hE7, 1'b1, 1'b1, 1'b0};

      // reset state
      wait_clk(3);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_data", rd_data, 8'h00);
      check("rst_full", fifo_full, 0);
      check("rst_busy", rx_busy, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_overrun", overrun, 0);
      reset_n = 1'b1;
      wait_clk(20);

      // single byte with exact push latency
      fork
         send_good(8'hA5);
         begin
            wait_clk(97);
            check("t1_valid_before", rd_valid, 0);
            wait_clk(1);
            check("t1_valid_after", rd_valid, 1);
            check("t1_data", rd_data, 8'hA5);
         end
      join
      check("t1_ferr", frame_err, 0);
      check("t1_overrun", overrun, 0);
      pop_check("t1_pop");

      // back-to-back bytes
      send_good(8'h00);
      send_good(8'hFF);
      send_good(8'h3C);
      wait_clk(1);
      check("t2_full", fifo_full, 0);
      pop_check("t2_pop0");
      pop_check("t2_pop1");
      pop_check("t2_pop2");
      check("t2_empty", rd_valid, 0);

      // overrun
      for (int i = 1; i <= 4; i++) send_good(8'(i));
      check("t3_full_after4", fifo_full, 1);
      check("t3_no_overrun_yet", overrun, 0);
      send_good(8'h05);
      wait_clk(1);
      check("t3_overrun", overrun, exp_overrun);
      check("t3_full_after5", fifo_full, 1);
      for (int i = 1; i <= 4; i++) pop_check("t3_pop");
      check("t3_empty", rd_valid, 0);
      pulse_clr();
      check("t3_overrun_clr", overrun, 0);

      // table-driven single frames
      for (int k = 0; k < 6; k++) begin
         wait_clk(CPB);
         if (vecs[k].stop) send_good(vecs[k].data);
         else send_frame(vecs[k].data, 1'b0);
         wait_clk(2);
         check($sformatf("vec%0d_valid", k), rd_valid, vecs[k].exp_valid);
         check($sformatf("vec%0d_ferr", k), frame_err, vecs[k].exp_ferr);
         check($sformatf("vec%0d_busy", k), rx_busy, 0);
         if (vecs[k].exp_valid) pop_check($sformatf("vec%0d_pop", k));
         pulse_clr();
      end
      check("tbl_ferr_clr", frame_err, 0);

      // bad stop bit with err_clr held across the set event, then resync after 10 clk high
      wait_clk(CPB);
      fork
         send_frame(8'h55, 1'b0);
         begin
            wait_clk(97);
            err_clr = 1'b1;
            wait_clk(1);
            check("t4_set_wins", frame_err, 1);
            err_clr = 1'b0;
            wait_clk(1);
            check("t4_ferr_sticky", frame_err, 1);
            check("t4_busy", rx_busy, 0);
            check("t4_no_push", rd_valid, 0);
         end
      join
      wait_clk(CPB);
      send_good(8'h12);
      wait_clk(1);
      pop_check("t4_pop_12");
      pulse_clr();
      check("t4_ferr_clr", frame_err, 0);

      // short low glitch on idle line
      wait_clk(CPB);
      rxd = 1'b0;
      wait_clk(3);
      rxd = 1'b1;
      wait_clk(2);
      check("t5_start_seen", rx_busy, 1);
      wait_clk(20);
      check("t5_busy", rx_busy, 0);
      check("t5_no_push", rd_valid, 0);
      check("t5_ferr", frame_err, 0);
      check("t5_overrun", overrun, 0);

      // reset during data bit 4; the remnant must not be decoded
      busy_seen  = 1'b0;
      valid_seen = 1'b0;
      fork
         send_frame(8'hC3, 1'b1);
         begin
            wait_clk(52);
            reset_n = 1'b0;
            wait_clk(3);
            reset_n = 1'b1;
            repeat (45) begin
               wait_clk(1);
               busy_seen  = busy_seen | rx_busy;
               valid_seen = valid_seen | rd_valid;
            end
         end
      join
      check("t6_no_busy", busy_seen, 0);
      check("t6_no_push", valid_seen, 0);
      send_good(8'h7E);
      wait_clk(1);
      pop_check("t6_pop_7e");
      check("t6_empty", rd_valid, 0);
      check("t6_ferr", frame_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
